// File: rtl/serial_tx.sv
// serial_tx: asynchronous-style serial transmitter (UART framing).
//
// Frames one DATA_BITS payload as: start bit (0), data bits LSB first,
// optional even-parity bit, STOP_BITS stop bits (1). Bit timing comes from
// Div_clk, a free-running square wave whose period is one bit time. Div_clk
// is resynchronised into the Clk_in domain and its rising edge becomes a
// single-cycle tick that advances the frame by one bit.
//
// Parameters
//   DATA_BITS  payload width, 5..9
//   PARITY_EN  1 inserts an even-parity bit after the data bits
//   STOP_BITS  number of stop bits, 1 or 2
//
// Ports
//   Clk_in     system clock, all flops on its rising edge
//   reset      synchronous reset, active-high
//   Div_clk    bit-rate square wave from the clock divider
//   tx_data    frame payload, captured only when a request is accepted
//   tx_start   request to send tx_data
//   tx_ready   registered, high only while idle and able to accept
//   tx_serial  serial line, idles high
//   tx_done    one-cycle pulse in the first idle cycle after a frame
module serial_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk_in,
  input  logic                 reset,
  input  logic                 Div_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic                 sync1, sync2, prev;
  logic                 tick;
  logic [2:0]           state;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 accept;
  logic                 shift_en;

  // Div_clk synchroniser and rising-edge detect
  assign tick = sync2 & ~prev;

  // tx_ready mirrors state == S_IDLE, so it doubles as the idle qualifier
  assign accept   = tx_ready & tx_start;
  // The line bit is always shreg[0]; it shifts at each tick that emits a data bit
  assign shift_en = tick & ((state == S_START) |
                            ((state == S_DATA) & (bit_idx != LAST_IDX)));

  // Frame control
  always_ff @(posedge Clk_in) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      state     <= S_IDLE;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      sync1   <= Div_clk;
      sync2   <= sync1;
      prev    <= sync2;
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A tick in the accept cycle is deliberately ignored: ARM waits
          // for the next one so the start bit is a full bit time long.
          if (accept) begin
            state    <= S_ARM;
            tx_ready <= 1'b0;
          end
        end
        S_ARM: begin
          if (tick) begin
            state     <= S_START;
            tx_serial <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            state     <= S_DATA;
            tx_serial <= shreg[0];
            bit_idx   <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state     <= S_PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= S_STOP;
                tx_serial <= 1'b1;
                stop_cnt  <= 1'b0;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shreg[0];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state     <= S_STOP;
            tx_serial <= 1'b1;
            stop_cnt  <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= S_IDLE;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          tx_ready  <= 1'b1;
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

  // Payload shift register and parity, loaded only on acceptance
  always_ff @(posedge Clk_in) begin
    if (accept) begin
      shreg   <= tx_data;
      par_bit <= even_parity(tx_data);
    end else if (shift_en) begin
      shreg   <= shreg >> 1;
    end
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter PARITY_EN, default 0; 1 inserts one even-parity bit after the data bits.
REQ-003 SHALL provide parameter STOP_BITS, default 1, number of stop bits (legal 1 or 2).
REQ-004 SHALL have port Clk_in  input  1  system clock; all flops clock on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-006 SHALL have port Div_clk  input  1  divided 50% duty square wave from the clock divider; one period = one bit time.
REQ-007 SHALL have port tx_data  input  DATA_BITS  frame payload, sampled only on acceptance.
REQ-008 SHALL have port tx_start  input  1  request to send tx_data.
REQ-009 SHALL have port tx_ready  output  1  high when idle and able to accept a request.
REQ-010 SHALL have port tx_serial  output  1  serial line, idle high, LSB first.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL pass Div_clk through two Clk_in flops (sync1, sync2) plus one history flop (prev); tick = sync2 AND NOT prev.
REQ-013 SHALL assert tick for exactly one Clk_in cycle per Div_clk rising edge, two cycles after sync1 first captures the high level.
REQ-014 SHALL implement states IDLE, ARM, START, DATA, PARITY, STOP; only IDLE is idle.
REQ-015 SHALL drive tx_ready = 1 exactly while state is IDLE, registered (no combinational path from tx_start).
REQ-016 SHALL accept a request when tx_start and tx_ready are both high at a Clk_in edge: latch tx_data into the shift register, compute parity, go to ARM; tx_ready low next cycle.
REQ-017 SHALL ignore tx_start while tx_ready is low; no queuing; latched data unchanged.
REQ-018 SHALL ignore a tick coinciding with acceptance; ARM waits for the next tick.
REQ-019 ARM: tx_serial stays 1; on tick go to START and drive tx_serial 0 from the following cycle.
REQ-020 START: on tick go to DATA and drive data bit 0.
REQ-021 DATA: each tick advances one bit, LSB first; bit index counter width ceil(log2(DATA_BITS)).
REQ-022 DATA: tick on bit DATA_BITS-1 goes to PARITY (drive XOR of all data bits) if PARITY_EN=1, else to STOP (drive 1).
REQ-023 PARITY: on tick go to STOP and drive 1.
REQ-024 STOP: holds 1 for STOP_BITS ticks; on the last of these go to IDLE.
REQ-025 SHALL pulse tx_done for one cycle, coincident with the first IDLE cycle; tx_ready rises the same cycle.
REQ-026 A request in that first IDLE cycle SHALL be accepted (back-to-back frames allowed).
REQ-027 Each line bit SHALL last exactly one Div_clk period (+/-1 Clk_in cycle); frame length is 1+DATA_BITS+PARITY_EN+STOP_BITS ticks after ARM.
REQ-028 With Div_clk stopped, the block SHALL wait indefinitely in its current state, holding tx_serial.

Reset
REQ-029 On reset high at a Clk_in edge: state IDLE, tx_serial 1, tx_ready 1, tx_done 0, counters 0, sync1/sync2/prev 0.
REQ-030 Reset SHALL override all activity, including mid-frame and simultaneous tx_start; the partial frame is abandoned with no tx_done pulse.
REQ-031 On the first cycle after reset releases, a request SHALL be accepted.

Verification
REQ-032 Reset, Div_clk 1 MHz from 50 MHz Clk_in (50-cycle period), idle -> tx_serial 1, tx_ready 1, tx_done 0 throughout.
REQ-033 8N1, tx_data 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each ~50 cycles; one tx_done pulse; tx_ready high.
REQ-034 PARITY_EN=1, tx_data 0x07 -> parity bit 1; 0x03 -> parity bit 0; 11-bit frames.
REQ-035 tx_start held high during 0x55 frame with tx_data changed to 0xFF -> 0x55 sent intact; 0xFF accepted in tx_done cycle and sent next.
REQ-036 reset asserted in DATA bit 3 -> tx_serial 1 next cycle, no tx_done; new 0x3C frame afterwards is correct.
REQ-037 tx_start coincident with tick -> start bit begins on the following tick, not the same one.
